// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between two byte producers. Requester 0 is the
//   processor MMIO store path and requester 1 is the debug/status source.
//   Accepted bytes are arbitrated round-robin into a 2**FIFO_DEPTH_LOG2-byte
//   TX FIFO. A small FSM drains the FIFO one byte at a time using the UART
//   core's wr/busy handshake.
//
// Parameters
//   FIFO_DEPTH_LOG2 : log2 of the FIFO depth (default 4, i.e. 16 bytes)
//   SETTLE_CYCLES   : cycles after the wr strobe during which uart_busy is
//                     ignored, covering the core's busy-rise latency (1..3)
//
// Ports
//   clk, reset           : clock and synchronous active-high reset
//   req0_valid/data/ready: requester 0 byte handshake (ready is combinational)
//   req1_valid/data/ready: requester 1 byte handshake (ready is combinational)
//   uart_wr              : one-cycle write strobe to the UART core
//   uart_tx_data         : byte for the UART core; holds its value between strobes
//   uart_busy            : UART core is transmitting
//   fifo_level           : number of bytes currently queued
//   fifo_full/fifo_empty : level == depth / level == 0
//
// Optional build macro
//   UART_TX_CRLF_EN : a LF (8'h0A) at the FIFO head is sent as CR then LF.
//                     The CR is generated here and never occupies a FIFO slot.
module uart_tx_arbiter #(
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int SETTLE_CYCLES   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_valid,
  input  logic [7:0]               req0_data,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [7:0]               req1_data,
  output logic                     req1_ready,
  output logic                     uart_wr,
  output logic [7:0]               uart_tx_data,
  input  logic                     uart_busy,
  output logic [FIFO_DEPTH_LOG2:0] fifo_level,
  output logic                     fifo_full,
  output logic                     fifo_empty
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] FULL_LEVEL = DEPTH[FIFO_DEPTH_LOG2:0];
  localparam logic [1:0] SETTLE_LAST = 2'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_SETTLE,
    S_WAIT
  } state_t;

  logic [7:0]                 fifo_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [FIFO_DEPTH_LOG2:0]   level_reg;
  logic                       rr_last_reg;
  state_t                     state_reg, state_next;
  logic [1:0]                 settle_cnt_reg, settle_cnt_next;
  logic [7:0]                 tx_data_reg, tx_data_next;
  logic                       grant0, grant1, push, pop;
  logic [7:0]                 push_data;
  logic [7:0]                 fifo_head;
`ifdef UART_TX_CRLF_EN
  logic                       cr_sent_reg, cr_sent_next;
  logic                       insert_cr;
`endif

  assign fifo_level = level_reg;
  assign fifo_full  = (level_reg == FULL_LEVEL);
  assign fifo_empty = (level_reg == '0);
  assign fifo_head  = fifo_mem[rd_ptr_reg];
  assign uart_tx_data = tx_data_reg;

  // Round-robin: on contention the requester that was not served last wins.
  // A same-cycle pop never frees room for this cycle's push.
  assign grant0 = !fifo_full && req0_valid && (!req1_valid || rr_last_reg);
  assign grant1 = !fifo_full && req1_valid && (!req0_valid || !rr_last_reg);
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign push      = grant0 || grant1;
  assign push_data = grant1 ? req1_data : req0_data;

  // FIFO storage: no reset, contents are qualified by the pointers/level.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
      rr_last_reg <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr_reg  <= wr_ptr_reg + 1'b1;
        rr_last_reg <= grant1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

`ifdef UART_TX_CRLF_EN
  // Head is stable from the IDLE decision through STROBE, so the same test
  // selects the CR byte and suppresses the pop.
  assign insert_cr = (fifo_head == 8'h0A) && !cr_sent_reg;
`endif

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      settle_cnt_reg <= '0;
      tx_data_reg    <= 8'h00;
`ifdef UART_TX_CRLF_EN
      cr_sent_reg    <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      settle_cnt_reg <= settle_cnt_next;
      tx_data_reg    <= tx_data_next;
`ifdef UART_TX_CRLF_EN
      cr_sent_reg    <= cr_sent_next;
`endif
    end
  end

  // Drain FSM next-state and outputs. The outgoing byte is captured on the
  // IDLE->STROBE edge so it is already valid while uart_wr is high.
  always_comb begin
    state_next      = state_reg;
    settle_cnt_next = settle_cnt_reg;
    tx_data_next    = tx_data_reg;
    uart_wr         = 1'b0;
    pop             = 1'b0;
`ifdef UART_TX_CRLF_EN
    cr_sent_next    = cr_sent_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (!fifo_empty && !uart_busy) begin
          state_next   = S_STROBE;
          tx_data_next = fifo_head;
`ifdef UART_TX_CRLF_EN
          if (insert_cr) begin
            tx_data_next = 8'h0D;
          end
`endif
        end
      end
      S_STROBE: begin
        uart_wr         = 1'b1;
        pop             = 1'b1;
        settle_cnt_next = '0;
        state_next      = S_SETTLE;
`ifdef UART_TX_CRLF_EN
        if (insert_cr) begin
          pop          = 1'b0;
          cr_sent_next = 1'b1;
        end else begin
          cr_sent_next = 1'b0;
        end
`endif
      end
      S_SETTLE: begin
        // uart_busy may not have risen yet; do not look at it here.
        if (settle_cnt_reg == SETTLE_LAST) begin
          state_next = S_WAIT;
        end else begin
          settle_cnt_next = settle_cnt_reg + 1'b1;
        end
      end
      S_WAIT: begin
        if (!uart_busy) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed vectors with hand-computed
// expectations. A UART model raises busy for busy_len cycles after each
// strobe (force_busy holds it high). Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       req1_ready;
  logic       uart_wr;
  logic [7:0] uart_tx_data;
  logic       uart_busy;
  logic [4:0] fifo_level;
  logic       fifo_full;
  logic       fifo_empty;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int busy_len = 10;
  logic force_busy = 1'b0;
  int ready0_cnt = 0;
  int both_cnt = 0;

  logic [7:0] strobe_q[$];
  int         strobe_cyc_q[$];
  int         grant_q[$];
  int         grant_cyc_q[$];

  uart_tx_arbiter #(.FIFO_DEPTH_LOG2(4), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .uart_wr(uart_wr), .uart_tx_data(uart_tx_data), .uart_busy(uart_busy),
    .fifo_level(fifo_level), .fifo_full(fifo_full), .fifo_empty(fifo_empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign uart_busy = force_busy || (busy_cnt != 0);

  // UART model and transaction logger.
  always @(negedge clk) begin
    if (uart_wr) begin
      strobe_q.push_back(uart_tx_data);
      strobe_cyc_q.push_back(cyc);
      busy_cnt <= busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (req0_valid && req0_ready) begin
      grant_q.push_back(0);
      grant_cyc_q.push_back(cyc);
    end
    if (req1_valid && req1_ready) begin
      grant_q.push_back(1);
      grant_cyc_q.push_back(cyc);
    end
    if (req0_ready) ready0_cnt <= ready0_cnt + 1;
    if (req0_ready && req1_ready) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("  ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte on requester 0 until accepted (bounded).
  task automatic push0(input logic [7:0] d, output logic ok);
    req0_valid = 1'b1;
    req0_data  = d;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (req0_ready) ok = 1'b1;
      tick();
    end
    req0_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int quiet;
    quiet = 0;
    for (int k = 0; k < budget && quiet < 4; k++) begin
      @(negedge clk);
      if (fifo_empty && !uart_busy && !uart_wr) quiet++;
      else quiet = 0;
    end
    tick();
    check(tag, quiet >= 4, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base_s, base_g, base_r, acc;
    logic ok, a0, a1;
    logic [7:0] d0, d1;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_uart_wr", uart_wr, 0);
    check("rst_tx_data", uart_tx_data, 8'h00);
    check("rst_level", fifo_level, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    tick();

    // ---------------- single byte ----------------
    busy_len = 10;
    base_s = strobe_q.size();
    base_g = grant_q.size();
    base_r = ready0_cnt;
    push0(8'h41, ok);
    check("single_accept", ok, 1);
    wait_idle(200, "single_drain");
    check("single_ready_cycles", ready0_cnt - base_r, 1);
    check("single_strobes", strobe_q.size() - base_s, 1);
    check("single_data", strobe_q[base_s], 8'h41);
    check("single_latency", strobe_cyc_q[base_s] - grant_cyc_q[base_g], 2);
    check("single_level", fifo_level, 0);

    // ---------------- round-robin ----------------
    do_reset();
    busy_len = 20;
    base_s = strobe_q.size();
    base_g = grant_q.size();
    d0 = 8'hA0;
    d1 = 8'hB0;
    acc = 0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < 40 && acc < 10; k++) begin
      req0_data = d0;
      req1_data = d1;
      @(negedge clk);
      a0 = req0_ready;
      a1 = req1_ready;
      tick();
      if (a0) begin d0++; acc++; end
      if (a1) begin d1++; acc++; end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("rr_accepted", acc, 10);
    check("rr_no_double_grant", both_cnt, 0);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("rr_grant%0d", i), grant_q[base_g+i], i % 2);
    end
    wait_idle(2000, "rr_drain");
    check("rr_strobes", strobe_q.size() - base_s, 10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("rr_byte%0d", i), strobe_q[base_s+i],
            (i % 2 == 0) ? 32'hA0 + i/2 : 32'hB0 + i/2);
    end

    // ---------------- full FIFO ----------------
    busy_len = 2;
    force_busy = 1'b1;
    base_s = strobe_q.size();
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      push0(8'hC0 + 8'(i), ok);
      if (ok) acc++;
    end
    check("full_accepted16", acc, 16);
    req0_valid = 1'b1;
    req0_data  = 8'hD0;
    @(negedge clk);
    check("full_flag", fifo_full, 1);
    check("full_level", fifo_level, 16);
    check("full_ready17", req0_ready, 0);
    tick();
    force_busy = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (req0_ready) ok = 1'b1;
      tick();
    end
    req0_valid = 1'b0;
    check("full_17th_accepted", ok, 1);
    check("full_17th_after_pop", grant_cyc_q[grant_cyc_q.size()-1], strobe_cyc_q[base_s] + 1);
    wait_idle(1000, "full_drain");
    check("full_strobes", strobe_q.size() - base_s, 17);
    for (int i = 0; i < 17; i++) begin
      check($sformatf("full_byte%0d", i), strobe_q[base_s+i], 32'hC0 + i);
    end

    // ---------------- simultaneous push/pop at level 5 ----------------
    force_busy = 1'b1;
    base_s = strobe_q.size();
    for (int i = 0; i < 5; i++) push0(8'hE0 + 8'(i), ok);
    @(negedge clk);
    check("pp_level_before", fifo_level, 5);
    tick();
    force_busy = 1'b0;
    busy_len = 3;
    tick();                       // FSM now in STROBE
    req0_valid = 1'b1;
    req0_data  = 8'hE5;
    tick();                       // push and pop on this edge
    req0_valid = 1'b0;
    @(negedge clk);
    check("pp_level_after", fifo_level, 5);
    check("pp_same_cycle", grant_cyc_q[grant_cyc_q.size()-1], strobe_cyc_q[base_s]);
    tick();
    wait_idle(500, "pp_drain");
    check("pp_strobes", strobe_q.size() - base_s, 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("pp_byte%0d", i), strobe_q[base_s+i], 32'hE0 + i);
    end

    // ---------------- reset mid-transfer ----------------
    busy_len = 30;
    for (int i = 0; i < 4; i++) push0(8'hF0 + 8'(i), ok);
    repeat (3) tick();
    @(negedge clk);
    check("mid_level_before", fifo_level, 3);
    tick();
    force_busy = 1'b1;
    do_reset();
    @(negedge clk);
    check("mid_level_after", fifo_level, 0);
    check("mid_empty_after", fifo_empty, 1);
    check("mid_wr_after", uart_wr, 0);
    tick();
    base_s = strobe_q.size();
    repeat (5) tick();
    check("mid_no_strobe_empty", strobe_q.size() - base_s, 0);
    push0(8'h77, ok);
    repeat (10) tick();
    check("mid_no_strobe_busy", strobe_q.size() - base_s, 0);
    force_busy = 1'b0;
    wait_idle(500, "mid_drain");
    check("mid_strobes", strobe_q.size() - base_s, 1);
    check("mid_byte", strobe_q[base_s], 8'h77);

    // ---------------- LF handling / idle-UART spacing ----------------
    busy_len = 0;
    base_s = strobe_q.size();
    push0(8'h0A, ok);
    push0(8'h42, ok);
    wait_idle(200, "lf_drain");
`ifdef UART_TX_CRLF_EN
    check("lf_strobes", strobe_q.size() - base_s, 3);
    check("lf_byte0", strobe_q[base_s], 8'h0D);
    check("lf_byte1", strobe_q[base_s+1], 8'h0A);
    check("lf_byte2", strobe_q[base_s+2], 8'h42);
    check("lf_spacing1", strobe_cyc_q[base_s+2] - strobe_cyc_q[base_s+1], 4);
`else
    check("lf_strobes", strobe_q.size() - base_s, 2);
    check("lf_byte0", strobe_q[base_s], 8'h0A);
    check("lf_byte1", strobe_q[base_s+1], 8'h42);
`endif
    check("lf_spacing0", strobe_cyc_q[base_s+1] - strobe_cyc_q[base_s], 4);
    check("lf_level", fifo_level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
